ram_loader: RTL
===============

Name: ram_loader

Overview:
- Boot/load engine directly upstream of the 2K x 16 synchronous system RAM.
- Accepts a framed byte stream (from UART receiver or host link) and assembles 16-bit words.
- Writes the words into RAM over the RAM's cs_b/rnw/address/data interface.
- Holds the CPU off the RAM bus while a load is in progress.

Parameters:
- ADDR_W, 11, RAM word-address width (2048 words).
- DATA_W, 16, RAM word width; must be 16 (two bytes per word).
- SYNC_BYTE, 8'hA5, frame start marker.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_data  input  8  incoming byte.
- in_valid  input  1  in_data valid this cycle.
- in_ready  output  1  loader accepts byte; transfer occurs when in_valid & in_ready.
- ram_address  output  ADDR_W  RAM word address.
- ram_wdata  output  DATA_W  write data; top level drives the RAM data bus when ram_wen=1.
- ram_wen  output  1  write-data bus enable for the top-level tristate.
- ram_cs_b  output  1  RAM chip select, active low.
- ram_rnw  output  1  RAM read-not-write.
- cpu_hold  output  1  high while a frame is being loaded; top level muxes the RAM bus to the loader.
- done  output  1  one-cycle pulse when a frame completes.
- error  output  1  sticky; cleared by reset or by the next SYNC_BYTE (checksum build only, else 0).

Behaviour:
- Reset values: in_ready=0, ram_cs_b=1, ram_rnw=1, ram_wen=0, ram_address=0, ram_wdata=0, cpu_hold=0, done=0, error=0. FSM returns to IDLE.
- Reset mid-frame aborts the frame. Already-written words remain in RAM; no partial write is issued.
- Frame format, high byte first: SYNC, ADDR_HI, ADDR_LO, CNT_HI, CNT_LO, then CNT words as DATA_HI, DATA_LO, then [CHK].
- Address bits above ADDR_W-1 are ignored.
- States and transitions:
  - IDLE: in_ready=1. Non-SYNC bytes are discarded. SYNC -> AHI; cpu_hold=1 from the next cycle.
  - AHI -> ALO -> CHI -> CLO: one accepted byte each.
  - CLO: if count==0, go to FIN (or CHK when the checksum feature is on); else go to DHI.
  - DHI -> DLO: one accepted byte each.
  - DLO: on byte accept, latch the word and go to WR.
  - WR: exactly one cycle with in_ready=0, ram_cs_b=0, ram_rnw=0, ram_wen=1, and address/data stable.
    - Next cycle: address increments modulo 2^ADDR_W (2047 wraps to 0) and count decrements.
    - If count becomes 0, go to FIN/CHK; else go to DHI.
  - FIN: done=1 for one cycle, cpu_hold=0, then IDLE.
- in_ready is 1 only in IDLE/AHI/ALO/CHI/CLO/DHI/DLO/CHK. It is 0 in WR and FIN.
- in_valid with in_ready=0 is held by the source, not lost.
- Byte-accept latency: a byte accepted in DLO produces its RAM write on the following cycle. Sustained throughput is 1 word per 3 cycles.
- Count width is 16 bits. Counts above 2048 wrap and overwrite earlier addresses; this is legal, no error.
- Outside WR: ram_cs_b=1, ram_rnw=1, ram_wen=0.
- A SYNC value inside a frame is treated as data, not as a new frame start.

Optional Feature:
- LOADER_CHECKSUM_EN defined:
  - Frame carries a trailing CHK byte. State CHK accepts it.
  - The running XOR of all bytes after SYNC (header and data) is compared with CHK.
  - Mismatch sets error=1. done still pulses.
- LOADER_CHECKSUM_EN undefined: no CHK state, error tied 0, frame ends after the last word.

Decomposition:
- Shared package opc_loader_pkg holds:
  - FSM state enum (IDLE, AHI, ALO, CHI, CLO, DHI, DLO, WR, CHK, FIN).
  - SYNC_BYTE default.
  - Byte-count width constant (16).
- No sub-module: the FSM and datapath are small enough for a single module.

Test Plan:
- Stream A5 00 10 00 02 12 34 56 78 -> writes 0x1234@0x010 then 0x5678@0x011, each cs_b=0/rnw=0 for exactly 1 cycle; done pulses once; cpu_hold high from the cycle after SYNC until FIN.
- Bytes 00 FF 3C then A5 00 00 00 00 -> garbage is ignored; zero-count frame pulses done with no RAM write.
- Start address 0x7FF, count 2, data AAAA BBBB -> writes at 0x7FF then 0x000.
- in_valid held high continuously -> in_ready drops during WR; no byte lost or duplicated; final RAM contents match the stream.
- reset asserted during the DLO of word 2 of 3 -> all outputs go to reset values next cycle, word 1 is in RAM, word 2 is not written; a new frame then loads normally.
- LOADER_CHECKSUM_EN: A5 00 00 00 01 12 34 with CHK=0x27 -> error=0; CHK=0x00 -> error=1; the next SYNC clears it.

Source files
------------

// File: rtl/opc_loader_pkg.sv
// ---------------------------------------------------------------------------
// opc_loader_pkg
//
// Shared definitions for the RAM boot loader:
//   - loader_state_t    : FSM state encoding
//   - SYNC_BYTE_DEFAULT : frame start marker
//   - CNT_W             : width of the frame word-count field
//   - state_accepts_byte: which states assert in_ready
// ---------------------------------------------------------------------------
package opc_loader_pkg;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
    localparam int         CNT_W             = 16;

    typedef enum logic [3:0] {
        ST_IDLE = 4'd0,
        ST_AHI  = 4'd1,
        ST_ALO  = 4'd2,
        ST_CHI  = 4'd3,
        ST_CLO  = 4'd4,
        ST_DHI  = 4'd5,
        ST_DLO  = 4'd6,
        ST_WR   = 4'd7,
        ST_CHK  = 4'd8,
        ST_FIN  = 4'd9
    } loader_state_t;

    // The loader takes bytes everywhere except the RAM write cycle and the
    // frame-complete cycle; the source holds its byte across those.
    function automatic logic state_accepts_byte(input loader_state_t s);
        return !((s == ST_WR) || (s == ST_FIN));
    endfunction

endpackage

// File: rtl/ram_loader.sv
// ---------------------------------------------------------------------------
// ram_loader
//
// Boot/load engine sitting in front of the 2K x 16 synchronous system RAM.
// Receives a framed byte stream, assembles 16-bit words (high byte first)
// and writes them into RAM, holding the CPU off the bus for the duration.
//
// Frame: SYNC, ADDR_HI, ADDR_LO, CNT_HI, CNT_LO, {DATA_HI, DATA_LO} x CNT
//        [, CHK when LOADER_CHECKSUM_EN is defined]
//
// Build option:
//   LOADER_CHECKSUM_EN - frame carries a trailing XOR checksum of every byte
//                        after SYNC; a mismatch sets the sticky error flag.
//                        Undefined: no CHK byte, error tied low.
//
// Ports:
//   clk, reset   - clock, synchronous active-high reset
//   in_data      - incoming byte
//   in_valid     - in_data valid this cycle
//   in_ready     - loader accepts byte
//   ram_address  - RAM word address
//   ram_wdata    - RAM write data (bus driven at top level when ram_wen=1)
//   ram_wen      - write-data bus enable for the top-level tristate
//   ram_cs_b     - RAM chip select, active low
//   ram_rnw      - RAM read-not-write
//   cpu_hold     - high while a frame is loading; top level muxes the bus
//   done         - one-cycle pulse at frame completion
//   error        - sticky checksum error, cleared by reset or next SYNC
//
// Handshake: a byte transfers on a rising edge where in_valid and in_ready
// are both high. in_ready never depends on in_valid; the source keeps
// in_valid/in_data stable until the transfer happens.
//
// The FSM state is held in the signal 'state' for checkers to bind to.
// ---------------------------------------------------------------------------
module ram_loader
    import opc_loader_pkg::*;
#(
    parameter int         ADDR_W    = 11,
    parameter int         DATA_W    = 16,   // two bytes per word; must be 16
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_wen,
    output logic              ram_cs_b,
    output logic              ram_rnw,
    output logic              cpu_hold,
    output logic              done,
    output logic              error
);

    // State that follows the last data word (or the header when count==0).
`ifdef LOADER_CHECKSUM_EN
    localparam loader_state_t AFTER_DATA = ST_CHK;
`else
    localparam loader_state_t AFTER_DATA = ST_FIN;
`endif

    loader_state_t     state;
    loader_state_t     state_next;

    logic              accept;
    logic [7:0]        hi_byte;     // first byte of each two-byte field
    logic [15:0]       byte_pair;   // {hi_byte, current byte}
    logic [ADDR_W-1:0] addr_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] wdata_q;

    assign accept    = in_valid && in_ready;
    assign byte_pair = {hi_byte, in_data};

    // -----------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // -----------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                // Anything other than SYNC while idle is line noise.
                if (accept && (in_data == SYNC_BYTE)) state_next = ST_AHI;
            end
            ST_AHI: if (accept) state_next = ST_ALO;
            ST_ALO: if (accept) state_next = ST_CHI;
            ST_CHI: if (accept) state_next = ST_CLO;
            ST_CLO: begin
                if (accept) begin
                    state_next = (byte_pair == 16'd0) ? AFTER_DATA : ST_DHI;
                end
            end
            ST_DHI: if (accept) state_next = ST_DLO;
            ST_DLO: if (accept) state_next = ST_WR;
            ST_WR: begin
                // cnt_q still holds the pre-decrement value here.
                state_next = (cnt_q == CNT_W'(1)) ? AFTER_DATA : ST_DHI;
            end
            ST_CHK: if (accept) state_next = ST_FIN;
            ST_FIN: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // -----------------------------------------------------------------
    // Datapath: header fields, word assembly, address/count stepping
    // -----------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            hi_byte <= 8'd0;
            addr_q  <= '0;
            cnt_q   <= '0;
            wdata_q <= '0;
        end else begin
            case (state)
                ST_AHI, ST_CHI, ST_DHI: begin
                    if (accept) hi_byte <= in_data;
                end
                ST_ALO: begin
                    // Upper address bits beyond the RAM size are dropped.
                    if (accept) addr_q <= byte_pair[ADDR_W-1:0];
                end
                ST_CLO: begin
                    if (accept) cnt_q <= byte_pair;
                end
                ST_DLO: begin
                    if (accept) wdata_q <= byte_pair[DATA_W-1:0];
                end
                ST_WR: begin
                    // Address wraps naturally modulo 2^ADDR_W; counts above
                    // the RAM size simply overwrite earlier words.
                    addr_q <= addr_q + ADDR_W'(1);
                    cnt_q  <= cnt_q - CNT_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

`ifdef LOADER_CHECKSUM_EN
    // -----------------------------------------------------------------
    // Running XOR of every byte after SYNC, compared with the CHK byte.
    // -----------------------------------------------------------------
    logic [7:0] chk_q;
    logic       error_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            chk_q   <= 8'd0;
            error_q <= 1'b0;
        end else if (accept) begin
            case (state)
                ST_IDLE: begin
                    if (in_data == SYNC_BYTE) begin
                        chk_q   <= 8'd0;
                        error_q <= 1'b0;
                    end
                end
                ST_AHI, ST_ALO, ST_CHI, ST_CLO, ST_DHI, ST_DLO: begin
                    chk_q <= chk_q ^ in_data;
                end
                ST_CHK: begin
                    if (chk_q != in_data) error_q <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end
`endif

    // -----------------------------------------------------------------
    // Output decode
    // -----------------------------------------------------------------
    always_comb begin
        // in_ready is masked during reset so the port shows its reset value
        // while reset is held, even though the FSM then sits in IDLE.
        in_ready    = state_accepts_byte(state) && !reset;
        ram_cs_b    = 1'b1;
        ram_rnw     = 1'b1;
        ram_wen     = 1'b0;
        ram_address = addr_q;
        ram_wdata   = wdata_q;
        cpu_hold    = (state != ST_IDLE) && (state != ST_FIN);
        done        = (state == ST_FIN);
`ifdef LOADER_CHECKSUM_EN
        error       = error_q;
`else
        error       = 1'b0;
`endif
        if (state == ST_WR) begin
            ram_cs_b = 1'b0;
            ram_rnw  = 1'b0;
            ram_wen  = 1'b1;
        end
    end

endmodule
